// File: rtl/flexbex_lsu_pipelined.sv
// Pipelined LSU between EX and the OBI data bus: in-order response FIFO, misaligned splits, read reassembly.
// Optional macro LSU_ERR_EN: report bus errors with the original byte address.
module flexbex_lsu_pipelined #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_req_i,
    output logic        lsu_ready_o,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_err_addr_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,
    output logic        busy_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_LO = 2'd1, S_HI = 2'd2;

    typedef struct packed {
        logic [1:0] typ;
        logic [1:0] off;
        logic       sgn;
        logic       we;
        logic       slo;
        logic       shi;
    } ent_t;

    logic [1:0]  r_state;
    logic        r_we, r_sgn;
    logic [1:0]  r_type;
    logic [31:0] r_addr, r_wdata, r_part;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_wptr, r_rptr;
    ent_t        r_fifo [MAX_OUTSTANDING];

    logic [1:0]  w_off;
    logic        w_misal, w_full, w_act, w_fire, w_final, w_acc, w_pop, w_err;
    logic [3:0]  w_be;
    logic [31:0] w_rot, w_lo, w_ext;
    logic [63:0] w_cat;
    ent_t        w_head, w_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_off   = r_addr[1:0];
    assign w_misal = (r_type == 2'b00 && w_off != 2'b00) || (r_type == 2'b01 && w_off == 2'b11);
    assign w_full  = (r_cnt == CW'(MAX_OUTSTANDING));
    assign w_act   = (r_state == S_LO) || (r_state == S_HI);
    assign w_fire  = data_req_o && data_gnt_i;
    assign w_final = w_fire && (r_state == S_HI || !w_misal);
    assign w_acc   = lsu_req_i && lsu_ready_o;

    assign lsu_ready_o   = (r_state == S_IDLE) || w_final;
    assign data_req_o    = w_act && !w_full;
    assign data_addr_o   = (r_state == S_HI) ? {r_addr[31:2] + 30'd1, 2'b00} : {r_addr[31:2], 2'b00};
    assign data_we_o     = r_we && w_act;
    assign data_be_o     = w_be;
    assign data_wdata_o  = w_rot;
    assign busy_o        = (r_state != S_IDLE) || (r_cnt != '0);
    assign outstanding_o = r_cnt;

    always_comb begin
        w_be = 4'b0000;
        if (r_state == S_LO) begin
            case (r_type)
                2'b00:   w_be = 4'b1111 << w_off;
                2'b01:   w_be = 4'b0011 << w_off;
                default: w_be = 4'b0001 << w_off;
            endcase
        end else if (r_state == S_HI) begin
            w_be = (r_type == 2'b00) ? ~(4'b1111 << w_off) : 4'b0001;
        end
    end

    always_comb begin
        case (w_off)
            2'd0:    w_rot = r_wdata;
            2'd1:    w_rot = {r_wdata[23:0], r_wdata[31:24]};
            2'd2:    w_rot = {r_wdata[15:0], r_wdata[31:16]};
            default: w_rot = {r_wdata[7:0],  r_wdata[31:8]};
        endcase
    end

    // Response side: the head entry tells how to stitch and extend the returning beat
    assign w_pop        = data_rvalid_i && (r_cnt != '0);
    assign w_head       = r_fifo[r_rptr];
    assign lsu_rvalid_o = w_pop && !w_head.slo;
    assign w_cat        = w_head.shi ? {data_rdata_i, r_part} : {32'b0, data_rdata_i};
    assign w_lo         = 32'(w_cat >> {w_head.off, 3'b000});

    always_comb begin
        case (w_head.typ)
            2'b00:   w_ext = w_lo;
            2'b01:   w_ext = {{16{w_head.sgn & w_lo[15]}}, w_lo[15:0]};
            default: w_ext = {{24{w_head.sgn & w_lo[7]}}, w_lo[7:0]};
        endcase
    end

`ifdef LSU_ERR_EN
    logic        r_err;
    logic [31:0] r_faddr [MAX_OUTSTANDING];
    assign w_err          = lsu_rvalid_o && (data_err_i || (w_head.shi && r_err));
    assign lsu_err_o      = w_err;
    assign lsu_err_addr_o = w_err ? r_faddr[r_rptr] : 32'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_err <= 1'b0;
        else if (w_pop && w_head.slo) r_err <= r_err | data_err_i;
        else if (lsu_rvalid_o)        r_err <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_fire) r_faddr[r_wptr] <= r_addr;
    end
`else
    assign w_err          = 1'b0;
    assign lsu_err_o      = 1'b0 & data_err_i;
    assign lsu_err_addr_o = 32'b0;
`endif

    assign lsu_rdata_o = (lsu_rvalid_o && !w_head.we && !w_err) ? w_ext : 32'b0;

    assign w_push = '{typ: r_type, off: w_off, sgn: r_sgn, we: r_we,
                      slo: (r_state == S_LO) && w_misal, shi: (r_state == S_HI)};

    always_ff @(posedge clk) begin
        if (w_fire) r_fifo[r_wptr] <= w_push;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_sgn   <= 1'b0;
            r_type  <= 2'b00;
            r_addr  <= 32'b0;
            r_wdata <= 32'b0;
            r_part  <= 32'b0;
            r_cnt   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_acc) begin
                r_state <= S_LO;
                r_we    <= lsu_we_i;
                r_sgn   <= lsu_sign_ext_i;
                r_type  <= lsu_type_i;
                r_addr  <= lsu_addr_i;
                r_wdata <= lsu_wdata_i;
            end else if (w_final) begin
                r_state <= S_IDLE;
            end else if (w_fire) begin
                r_state <= S_HI;
            end
            if (w_fire) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            if (w_pop && w_head.slo) r_part <= data_rdata_i;
            case ({w_fire, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_flexbex_lsu_pipelined.sv
// Directed bench for flexbex_lsu_pipelined: inputs change on the falling edge, outputs checked 1ns later.
module tb_flexbex_lsu_pipelined;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        lsu_req_i = 0, lsu_we_i = 0, lsu_sign_ext_i = 0;
    logic [1:0]  lsu_type_i = 0;
    logic [31:0] lsu_addr_i = 0, lsu_wdata_i = 0;
    logic        lsu_ready_o, lsu_rvalid_o, lsu_err_o;
    logic [31:0] lsu_rdata_o, lsu_err_addr_o;
    logic        data_req_o, data_we_o, busy_o;
    logic        data_gnt_i = 0, data_rvalid_i = 0, data_err_i = 0;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i = 0;
    logic [3:0]  data_be_o;
    logic [1:0]  outstanding_o;
    int n_run = 0, n_fail = 0;

    flexbex_lsu_pipelined #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_req_i(lsu_req_i), .lsu_ready_o(lsu_ready_o), .lsu_we_i(lsu_we_i),
        .lsu_type_i(lsu_type_i), .lsu_sign_ext_i(lsu_sign_ext_i), .lsu_addr_i(lsu_addr_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .lsu_err_o(lsu_err_o), .lsu_err_addr_o(lsu_err_addr_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_rdata_i(data_rdata_i),
        .busy_o(busy_o), .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic req, input logic we, input logic [1:0] typ, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        lsu_req_i = req; lsu_we_i = we; lsu_type_i = typ; lsu_sign_ext_i = sgn;
        lsu_addr_i = addr; lsu_wdata_i = wdata;
    endtask

    task automatic bus(input logic gnt, input logic rv, input logic err, input logic [31:0] rdata);
        data_gnt_i = gnt; data_rvalid_i = rv; data_err_i = err; data_rdata_i = rdata;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_run++; if (data_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b exp 0", data_req_o); end
        n_run++; if (lsu_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got %b exp 0", lsu_rvalid_o); end
        n_run++; if (data_be_o !== 4'b0) begin n_fail++; $display("FAIL rst_be got %b exp 0000", data_be_o); end
        n_run++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL rst_outst got %0d exp 0", outstanding_o); end
        n_run++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy_o); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_run++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", lsu_ready_o); end
        n_run++; if (data_addr_o !== 32'b0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", data_addr_o); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            issue(c < 3, 1'b0, 2'b00, 1'b0, 32'h100 + 4 * c, 32'b0);
            bus(1'b1, (c >= 2 && c <= 4), 1'b0, 32'hD000_0000 + c);
            #1;
            if (c < 3) begin
                n_run++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready c%0d got %b exp 1", c, lsu_ready_o); end
            end
            n_run++; if (lsu_rvalid_o !== (c >= 2 && c <= 4)) begin n_fail++; $display("FAIL b2b_rvalid c%0d got %b", c, lsu_rvalid_o); end
            if (c >= 2 && c <= 4) begin
                n_run++; if (lsu_rdata_o !== 32'hD000_0000 + c) begin n_fail++; $display("FAIL b2b_rdata c%0d got %h exp %h", c, lsu_rdata_o, 32'hD000_0000 + c); end
            end
            if (c >= 1 && c <= 3) begin
                n_run++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h100 + 4 * (c - 1)) begin n_fail++; $display("FAIL b2b_beat c%0d got req %b addr %h", c, data_req_o, data_addr_o); end
            end
            n_run++; if (outstanding_o > 2'd2) begin n_fail++; $display("FAIL b2b_outst c%0d got %0d exp <=2", c, outstanding_o); end
        end
        @(negedge clk); bus(0, 0, 0, 0); #1;
        n_run++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got %b exp 0", busy_o); end
    endtask

    task automatic test_misaligned_word();
        @(negedge clk); issue(1, 0, 2'b00, 0, 32'h1001, 0); bus(0, 0, 0, 0);
        @(negedge clk); issue(0, 0, 2'b00, 0, 0, 0); bus(1, 0, 0, 0); #1;
        n_run++; if (data_addr_o !== 32'h1000 || data_be_o !== 4'b1110) begin n_fail++; $display("FAIL mis_lo got %h/%b exp 00001000/1110", data_addr_o, data_be_o); end
        n_run++; if (lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL mis_ready_lo got %b exp 0", lsu_ready_o); end
        @(negedge clk); bus(1, 1, 0, 32'hAABBCCDD); #1;
        n_run++; if (data_addr_o !== 32'h1004 || data_be_o !== 4'b0001) begin n_fail++; $display("FAIL mis_hi got %h/%b exp 00001004/0001", data_addr_o, data_be_o); end
        n_run++; if (lsu_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL mis_early got %b exp 0", lsu_rvalid_o); end
        @(negedge clk); bus(0, 1, 0, 32'h11223344); #1;
        n_run++; if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 32'h44AABBCC) begin n_fail++; $display("FAIL mis_data got %b/%h exp 1/44aabbcc", lsu_rvalid_o, lsu_rdata_o); end
        @(negedge clk); bus(0, 0, 0, 0); #1;
        n_run++; if (busy_o !== 1'b0 || lsu_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL mis_done got busy %b rvalid %b exp 0/0", busy_o, lsu_rvalid_o); end
    endtask

    task automatic test_byte_ext(input logic sgn, input logic [31:0] exp);
        @(negedge clk); issue(1, 0, 2'b10, sgn, 32'h2003, 0); bus(0, 0, 0, 0);
        @(negedge clk); issue(0, 0, 2'b00, 0, 0, 0); bus(1, 0, 0, 0); #1;
        n_run++; if (data_addr_o !== 32'h2000 || data_be_o !== 4'b1000) begin n_fail++; $display("FAIL byte_beat got %h/%b exp 00002000/1000", data_addr_o, data_be_o); end
        @(negedge clk); bus(0, 1, 0, 32'h8000_0000); #1;
        n_run++; if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== exp) begin n_fail++; $display("FAIL byte_ext s%b got %b/%h exp 1/%h", sgn, lsu_rvalid_o, lsu_rdata_o, exp); end
        @(negedge clk); bus(0, 0, 0, 0);
    endtask

    task automatic test_half_store();
        @(negedge clk); issue(1, 1, 2'b01, 0, 32'h3003, 32'h0000BEEF); bus(0, 0, 0, 0);
        @(negedge clk); issue(0, 0, 2'b00, 0, 0, 0); bus(1, 0, 0, 0); #1;
        n_run++; if (data_addr_o !== 32'h3000 || data_be_o !== 4'b1000 || data_we_o !== 1'b1) begin n_fail++; $display("FAIL hst_lo got %h/%b/%b exp 00003000/1000/1", data_addr_o, data_be_o, data_we_o); end
        n_run++; if (data_wdata_o !== 32'hEF0000BE) begin n_fail++; $display("FAIL hst_wdata_lo got %h exp ef0000be", data_wdata_o); end
        @(negedge clk); bus(1, 1, 0, 0); #1;
        n_run++; if (data_addr_o !== 32'h3004 || data_be_o !== 4'b0001 || data_wdata_o !== 32'hEF0000BE) begin n_fail++; $display("FAIL hst_hi got %h/%b/%h exp 00003004/0001/ef0000be", data_addr_o, data_be_o, data_wdata_o); end
        n_run++; if (lsu_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL hst_early got %b exp 0", lsu_rvalid_o); end
        @(negedge clk); bus(0, 1, 0, 32'hFFFF_FFFF); #1;
        n_run++; if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 32'b0) begin n_fail++; $display("FAIL hst_done got %b/%h exp 1/0", lsu_rvalid_o, lsu_rdata_o); end
        @(negedge clk); bus(0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); issue(1, 0, 2'b00, 0, 32'h400 + 4 * c, 0); bus(1, 0, 0, 0);
        end
        for (int c = 3; c < 5; c++) begin
            @(negedge clk); issue(0, 0, 2'b00, 0, 0, 0); #1;
            n_run++; if (data_req_o !== 1'b0 || lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_stall c%0d got req %b ready %b exp 0/0", c, data_req_o, lsu_ready_o); end
            n_run++; if (outstanding_o !== 2'd2) begin n_fail++; $display("FAIL bp_outst c%0d got %0d exp 2", c, outstanding_o); end
        end
        @(negedge clk); bus(1, 1, 0, 32'hA); #1;
        n_run++; if (data_req_o !== 1'b0 || lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 32'hA) begin n_fail++; $display("FAIL bp_pop1 got req %b rv %b data %h exp 0/1/a", data_req_o, lsu_rvalid_o, lsu_rdata_o); end
        @(negedge clk); bus(1, 1, 0, 32'hB); #1;
        n_run++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h408 || lsu_rdata_o !== 32'hB) begin n_fail++; $display("FAIL bp_resume got req %b addr %h data %h exp 1/408/b", data_req_o, data_addr_o, lsu_rdata_o); end
        @(negedge clk); bus(0, 1, 0, 32'hC); #1;
        n_run++; if (lsu_rvalid_o !== 1'b1 || lsu_rdata_o !== 32'hC) begin n_fail++; $display("FAIL bp_pop3 got %b/%h exp 1/c", lsu_rvalid_o, lsu_rdata_o); end
        @(negedge clk); bus(0, 0, 0, 0); #1;
        n_run++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL bp_drain got %0d exp 0", outstanding_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); issue(1, 0, 2'b00, 0, 32'h500, 0); bus(0, 0, 0, 0);
        @(negedge clk); issue(0, 0, 2'b00, 0, 0, 0); bus(1, 0, 0, 0);
        @(negedge clk); bus(0, 0, 0, 0); rst_n = 1'b0; #1;
        n_run++; if (outstanding_o !== 2'd0) begin n_fail++; $display("FAIL rmid_outst got %0d exp 0", outstanding_o); end
        @(negedge clk); rst_n = 1'b1; bus(0, 1, 0, 32'h1234); #1;
        n_run++; if (lsu_rvalid_o !== 1'b0 || lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ignore got rv %b ready %b exp 0/1", lsu_rvalid_o, lsu_ready_o); end
        @(negedge clk); bus(0, 0, 0, 0); #1;
        n_run++; if (outstanding_o !== 2'd0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rmid_idle got %0d/%b exp 0/0", outstanding_o, busy_o); end
    endtask

`ifdef LSU_ERR_EN
    task automatic test_err();
        @(negedge clk); issue(1, 0, 2'b00, 0, 32'hFFFF_FFFE, 0); bus(0, 0, 0, 0);
        @(negedge clk); issue(0, 0, 2'b00, 0, 0, 0); bus(1, 0, 0, 0); #1;
        n_run++; if (data_addr_o !== 32'hFFFF_FFFC || data_be_o !== 4'b1100) begin n_fail++; $display("FAIL err_lo got %h/%b exp fffffffc/1100", data_addr_o, data_be_o); end
        @(negedge clk); bus(1, 1, 1, 32'h5555_5555); #1;
        n_run++; if (data_addr_o !== 32'h0 || data_be_o !== 4'b0011) begin n_fail++; $display("FAIL err_wrap got %h/%b exp 0/0011", data_addr_o, data_be_o); end
        @(negedge clk); bus(0, 1, 0, 32'h6666_6666); #1;
        n_run++; if (lsu_rvalid_o !== 1'b1 || lsu_err_o !== 1'b1 || lsu_err_addr_o !== 32'hFFFF_FFFE || lsu_rdata_o !== 32'b0) begin n_fail++; $display("FAIL err_done got rv %b err %b addr %h data %h exp 1/1/fffffffe/0", lsu_rvalid_o, lsu_err_o, lsu_err_addr_o, lsu_rdata_o); end
        @(negedge clk); bus(0, 0, 0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_misaligned_word();
        test_byte_ext(1'b1, 32'hFFFF_FF80);
        test_byte_ext(1'b0, 32'h0000_0080);
        test_half_store();
        test_backpressure();
        test_reset_mid();
`ifdef LSU_ERR_EN
        test_err();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
